// File: rtl/fft_frame_writer.sv
// fft_frame_writer
// Collects one frame of signed PCM samples from a valid/ready stream and writes
// them into the FFT frame RAM as complex words (real = sample, imag = 0). The
// write address is optionally bit-reversed so the FFT can read in natural order.
// The frame is held in RAM until the downstream FFT acknowledges it.

module fft_frame_writer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int BIT_REVERSE  = 1
) (
  input  logic                    wr_clk,
  input  logic                    tb_wr_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cont,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    frame_done,
  input  logic                    frame_ack,
  output logic [ADDR_WIDTH:0]     sample_cnt
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     sampleCnt_q;
  logic                    frameDone_q;
  logic                    wrEn_q;
  logic [ADDR_WIDTH-1:0]   wrAddr_q;
  logic [DATA_WIDTH-1:0]   wrData_q;

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   natAddr;
  logic [ADDR_WIDTH-1:0]   revAddr;
  logic [ADDR_WIDTH-1:0]   wrAddr_d;
  logic [HALF-1:0]         realPart;
  logic [DATA_WIDTH-1:0]   wrData_d;

  // Ready only while filling; abort drops ready in the same cycle so nothing is taken
  always_comb begin
    s_ready = (state_q == FILL) && !abort;
    accept  = s_ready && s_valid;
  end

  // Address and data of the write that an accepted sample will produce
  always_comb begin
    natAddr = sampleCnt_q[ADDR_WIDTH-1:0];
    revAddr = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      revAddr[i] = natAddr[ADDR_WIDTH-1-i];
    end
    wrAddr_d = (BIT_REVERSE != 0) ? revAddr : natAddr;
    realPart = HALF'($signed(s_data));
    wrData_d = {realPart, {HALF{1'b0}}};
  end

  // Frame state machine with registered RAM port, frame_done and sample counter
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      frameDone_q <= 1'b0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
    end else begin
      wrEn_q <= accept;
      if (accept) begin
        wrAddr_q <= wrAddr_d;
        wrData_q <= wrData_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FILL;
            sampleCnt_q <= '0;
          end
        end
        FILL: begin
          if (abort) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
          end else if (s_valid) begin
            sampleCnt_q <= sampleCnt_q + CNT_ONE;
            if (sampleCnt_q == LAST_IDX) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state_q     <= IDLE;
            frameDone_q <= 1'b0;
          end else if (!frameDone_q) begin
            frameDone_q <= 1'b1;
          end else if (frame_ack) begin
            frameDone_q <= 1'b0;
            sampleCnt_q <= '0;
            state_q     <= cont ? FILL : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign frame_done = frameDone_q;
  assign sample_cnt = sampleCnt_q;

endmodule
